// File: rtl/rep_dec.sv
// rep_dec: recovers one WIDTH-bit value from a COPIES-lane replicated word by per-bit
// majority vote. It also flags any lane that differs from lane 0 and can keep a
// saturating count of mismatched words.
//   Latency: COPIES cycles from capture to out_valid. One word is in flight at a time.
//   Backpressure: the result is held in DONE until out_ready, and in_ready stays low until then.
// Ports:
//   clk, rst (async, active-high)
//   in_valid/in_ready/in          replicated word in; lane k = in[k*WIDTH +: WIDTH]
//   out_valid/out_ready/out       voted value out
//   mismatch                      at least one lane differed from lane 0
//   err_cnt                       saturating count of mismatched words
// Build option: define REP_DEC_ERR_CNT_EN to build the err_cnt counter.
// Without it, err_cnt is tied to 0.
module rep_dec #(
  parameter int WIDTH  = 8,
  parameter int COPIES = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH*COPIES-1:0] in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int OW = $clog2(COPIES + 1);  // ones-counter width
  localparam int IW = $clog2(COPIES);      // lane index width
  // The vote compares 2*ones against COPIES, so odd and even COPIES share one rule
  // and no fractional half is needed.
  localparam logic [OW:0] COPIES_CMP = (OW + 1)'(COPIES);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                    state_q, state_d;
  logic [WIDTH*COPIES-1:0]   sh_q, sh_d;
  logic [WIDTH-1:0]          lane0_q, lane0_d;
  logic [WIDTH-1:0][OW-1:0]  ones_q, ones_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic                      diff_q, diff_d;
  logic [WIDTH-1:0]          out_q, out_d;
  logic                      mis_q, mis_d;

  logic [WIDTH-1:0]          lane;
  logic                      lane_diff;
  logic                      last_lane;
  logic [WIDTH-1:0][OW-1:0]  ones_nx;
  logic [WIDTH-1:0]          vote;

  // The lane under scan is always the low slice of the shift register.
  always_comb begin
    lane      = sh_q[WIDTH-1:0];
    lane_diff = (lane != lane0_q);
    last_lane = (idx_q == IW'(COPIES - 1));
    ones_nx   = '0;
    vote      = '0;
    for (int b = 0; b < WIDTH; b++) begin
      ones_nx[b] = ones_q[b] + OW'(lane[b]);
      if ({ones_nx[b], 1'b0} > COPIES_CMP) begin
        vote[b] = 1'b1;
      end else if ({ones_nx[b], 1'b0} < COPIES_CMP) begin
        vote[b] = 1'b0;
      end else begin
        vote[b] = lane0_q[b];  // exact tie: lane 0 wins
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    lane0_d = lane0_q;
    ones_d  = ones_q;
    idx_d   = idx_q;
    diff_d  = diff_q;
    out_d   = out_q;
    mis_d   = mis_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = in;
          lane0_d = in[WIDTH-1:0];
          ones_d  = '0;
          idx_d   = '0;
          diff_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        sh_d   = sh_q >> WIDTH;
        ones_d = ones_nx;
        idx_d  = idx_q + IW'(1);
        diff_d = diff_q | lane_diff;
        if (last_lane) begin
          out_d   = vote;
          mis_d   = diff_q | lane_diff;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      lane0_q <= '0;
      ones_q  <= '0;
      idx_q   <= '0;
      diff_q  <= 1'b0;
      out_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      lane0_q <= lane0_d;
      ones_q  <= ones_d;
      idx_q   <= idx_d;
      diff_q  <= diff_d;
      out_q   <= out_d;
      mis_q   <= mis_d;
    end
  end

  // in_ready is gated by rst so that it reads 0 for the whole reset pulse.
  // In that window the state register already holds IDLE.
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign mismatch  = mis_q;

`ifdef REP_DEC_ERR_CNT_EN
  logic             err_inc;
  logic [CNT_W-1:0] err_q, err_d;

  always_comb begin
    err_inc = (state_q == SCAN) && last_lane && mis_d;
    err_d   = err_q;
    if (err_inc && (err_q != {CNT_W{1'b1}})) begin
      err_d = err_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_rep_dec.sv
// tb_rep_dec: randomized scoreboard bench for rep_dec (WIDTH=8, COPIES=4, CNT_W=2).
// A driver issues words and pushes reference-model results into a queue.
// A monitor pops the queue and checks each presented result, its latency and in_ready.
module tb_rep_dec;
  localparam int W  = 8;
  localparam int C  = 4;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W*C-1:0] in_w = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_w;
  logic           mismatch;
  logic [CW-1:0]  err_cnt;

  rep_dec #(.WIDTH(W), .COPIES(C), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in(in_w),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_w),
    .mismatch(mismatch), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0]  val;
    logic          mis;
    logic [CW-1:0] err;
    int            cap;
    int            hold;
    bit            rnd;
  } exp_t;

  exp_t q[$];
  int   npass = 0;
  int   ntot = 0;
  int   err_model = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    ntot++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  // Reference model: count ones per bit over all lanes, then apply the vote rule.
  function automatic exp_t model(input logic [W*C-1:0] w);
    exp_t         e;
    logic [W-1:0] l0;
    int           ones;
    l0    = w[W-1:0];
    e.mis = 1'b0;
    e.val = '0;
    for (int k = 1; k < C; k++) if (w[k*W +: W] != l0) e.mis = 1'b1;
    for (int b = 0; b < W; b++) begin
      ones = 0;
      for (int k = 0; k < C; k++) ones += int'(w[k*W + b]);
      if (2 * ones > C)      e.val[b] = 1'b1;
      else if (2 * ones < C) e.val[b] = 1'b0;
      else                   e.val[b] = l0[b];
    end
    e.cap  = 0;
    e.hold = 0;
    e.rnd  = 1'b0;
    e.err  = '0;
    return e;
  endfunction

  function automatic logic [W*C-1:0] corrupt_one(input logic [W-1:0] b);
    logic [W*C-1:0] w;
    int             k;
    w = {C{b}};
    k = $urandom_range(0, C - 1);
    w[k*W +: W] = w[k*W +: W] ^ W'($urandom_range(1, 255));
    return w;
  endfunction

  function automatic logic [W*C-1:0] rand_word();
    logic [W-1:0] b;
    b = W'($urandom);
    case ($urandom_range(0, 2))
      0:       return {C{b}};
      1:       return corrupt_one(b);
      default: return (W*C)'($urandom);
    endcase
  endfunction

  // While the DUT is busy, in_valid is held high with junk data.
  // Such a word must never be captured.
  task automatic send(input logic [W*C-1:0] w, input int gap, input int hold, input bit rnd);
    exp_t e;
    int   guard;
    int   g;
    guard = 0;
    g     = gap;
    @(negedge clk);
    while ((!in_ready || g > 0) && guard < 1000) begin
      if (in_ready) begin
        g--;
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_w     = (W*C)'($urandom);
      end
      guard++;
      @(negedge clk);
    end
    if (guard >= 1000) begin
      timeout("send_wait_in_ready");
      return;
    end
    e = model(w);
`ifdef REP_DEC_ERR_CNT_EN
    if (e.mis && err_model < (1 << CW) - 1) err_model++;
`endif
    e.err  = CW'(err_model);
    e.cap  = cyc + 1;
    e.hold = hold;
    e.rnd  = rnd;
    q.push_back(e);
    in_valid = 1'b1;
    in_w     = w;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      guard++;
    end while ((q.size() != 0 || out_valid) && guard < 1000);
    if (guard >= 1000) timeout("drain");
  endtask

  // Monitor: sets out_ready for the coming edge first, then pops when that edge consumes.
  initial begin
    bit   pv;
    bit   chk_ir;
    bit   have;
    int   n;
    exp_t cur;
    pv     = 1'b0;
    chk_ir = 1'b0;
    have   = 1'b0;
    n      = 0;
    cur    = model('0);
    forever begin
      @(negedge clk);
      if (rst) begin
        pv     = 1'b0;
        chk_ir = 1'b0;
      end else begin
        if (chk_ir) begin
          chk("in_ready_after_consume", 32'(in_ready), 32'd1);
          chk_ir = 1'b0;
        end
        if (out_valid) begin
          if (!pv) begin
            ntot++;
            if (q.size() == 0) begin
              have = 1'b0;
              $display("FAIL spurious_output: out_valid with empty queue, out=0x%0h (cycle %0d)",
                       out_w, cyc);
            end else begin
              npass++;
              have = 1'b1;
              cur  = q[0];
              chk("latency", 32'(cyc - cur.cap), 32'(C));
            end
            n = 0;
          end
          if (have) begin
            chk("out", 32'(out_w), 32'(cur.val));
            chk("mismatch", 32'(mismatch), 32'(cur.mis));
            chk("err_cnt", 32'(err_cnt), 32'(cur.err));
          end
          chk("in_ready_busy", 32'(in_ready), 32'd0);
          n++;
          if (n <= cur.hold) out_ready = 1'b0;
          else if (cur.rnd)  out_ready = 1'($urandom_range(0, 1));
          else               out_ready = 1'b1;
          if (out_ready) begin
            if (have) void'(q.pop_front());
            chk_ir = 1'b1;
            pv     = 1'b0;
            have   = 1'b0;
          end else begin
            pv = 1'b1;
          end
        end else begin
          pv        = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out_w), 32'd0);
    chk("rst_mismatch", 32'(mismatch), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    #1 rst = 1'b0;
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Clean word, single bad lane, and tie-breaking in both directions.
    send(32'h02020202, 0, 0, 1'b0);
    send(32'h7E7E7F7E, 0, 0, 1'b0);
    send(32'hFF00FF00, 0, 0, 1'b0);
    send(32'h00FF00FF, 0, 0, 1'b0);
    // Backpressure for 6 cycles while in_valid stays high with changing data.
    send(32'hA8A8A8A8, 0, 6, 1'b0);
    drain();

    // Reset asserted mid-scan, just after the second lane edge.
    send(32'hFCFCFCFD, 0, 0, 1'b0);
    @(posedge clk);  // E0: capture
    #1 chk("mid_rst_captured", 32'(in_ready), 32'd0);
    @(posedge clk);  // E1
    @(posedge clk);  // E2
    #1 rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out", 32'(out_w), 32'd0);
    chk("mid_rst_mismatch", 32'(mismatch), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    q.delete();
    err_model = 0;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Saturation: five words, each with exactly one corrupted lane.
    for (int i = 0; i < 5; i++) send(corrupt_one(W'($urandom)), 0, 0, 1'b0);
    drain();

    // Random traffic with random idle gaps, holds and output readiness.
    for (int i = 0; i < 40; i++) begin
      send(rand_word(), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);
    end
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
